wb_sdram_arbiter: RTL
=====================

// Module: wb_sdram_arbiter
// PURPOSE
//  Two-master Wishbone B3 classic arbiter that shares the single SDRAM controller
//  Wishbone port between the CPU instruction bus (m0) and the data bus (m1).
//  Grants one master per bus cycle (whole wb_cyc assertion), round-robin or fixed priority.
//  Includes a per-transfer ack watchdog that returns err instead of hanging the CPU.
// PARAMETERS
//  AW              32   address width
//  DW              32   data width; select width is DW/8
//  ROUND_ROBIN     1    1 = round-robin between m0/m1; 0 = fixed priority, m1 wins
//  TIMEOUT_CYCLES  1023 cycles s_stb may wait for ack/err before forced err; 0 = disabled
//  TO_W            10   watchdog counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  wb_clk_i    in   1      system clock; all logic on rising edge
//  wb_rst_i    in   1      synchronous active-high reset
//  m0_adr_i    in   AW     master0 (ibus) address; m1_* are identical for master1 (dbus)
//  m0_dat_i    in   DW     master0 write data
//  m0_sel_i    in   DW/8   master0 byte selects
//  m0_we_i     in   1      master0 write enable
//  m0_cyc_i    in   1      master0 cycle
//  m0_stb_i    in   1      master0 strobe
//  m0_dat_o    out  DW     read data to master0
//  m0_ack_o    out  1      ack to master0
//  m0_err_o    out  1      err to master0 (slave err or watchdog)
//  m1_*        -    -      same set as m0_*, for master1
//  s_adr_o     out  AW     to SDRAM controller port
//  s_dat_o     out  DW     write data to slave
//  s_sel_o     out  DW/8   byte selects to slave
//  s_we_o      out  1      write enable to slave
//  s_cyc_o     out  1      cycle to slave
//  s_stb_o     out  1      strobe to slave
//  s_dat_i     in   DW     read data from slave
//  s_ack_i     in   1      ack from slave
//  s_err_i     in   1      err from slave
//  grant_o     out  2      one-hot current grant {m1,m0}; 00 = idle (debug/perf)
// BEHAVIOUR
//  - FSM states IDLE, G0, G1 (registered). Reset -> IDLE, last-granted = m1 (m0 wins first tie).
//  - IDLE: no request -> stay. Only m0_cyc -> G0; only m1_cyc -> G1. Both: RR gives the master
//    not last granted; fixed priority gives m1. Grant takes effect the cycle after the request.
//  - Gx: stay while mx_cyc_i=1; mx_cyc_i=0 -> IDLE, last-granted <= x. No direct G0->G1 hop;
//    one IDLE cycle always separates grants (slave sees cyc low >= 1 cycle).
//  - Routing (combinational from the state): s_adr/dat/sel/we/cyc/stb follow the granted
//    master; IDLE drives s_cyc_o=s_stb_o=0, other slave outputs 0.
//    mx_dat_o=s_dat_i for both masters; mx_ack_o=s_ack_i & grant[x]; mx_err_o per watchdog rule.
//  - Ungranted master sees ack=err=0 and simply waits; its request is never dropped.
//  - Added latency: 1 cycle from cyc to grant; 0 cycles on stb->slave and ack->master when granted.
//  - Watchdog: counter cleared when not granted, when s_stb_o=0, or on s_ack_i|s_err_i;
//    else increments. When count==TIMEOUT_CYCLES-1 and no ack/err this cycle: granted
//    mx_err_o=1 for that one cycle and s_stb_o forced 0 that cycle; counter clears.
//  - mx_err_o = grant[x] & (s_err_i | watchdog_fire). Ack and err never both high to a master
//    (watchdog cannot fire on an ack cycle).
//  - Reset mid-transfer: next cycle state IDLE, all slave strobes/cycles 0, counter 0.
//  - grant_o reset value 2'b00; all master ack/err outputs 0 in reset and in IDLE.
// TESTING
//  1 m0_cyc/stb at t0, slave acks t2 -> grant_o=01 at t1, m0_ack_o=1 at t2, m1 acks stay 0.
//  2 m0,m1 assert cyc same cycle after reset, RR=1 -> m0 served, IDLE 1 cycle, then grant_o=10.
//  3 ROUND_ROBIN=0, both requesting continuously -> m1 granted every arbitration, m0 only when m1_cyc=0.
//  4 Granted m1 holds cyc over 4 stb/ack beats while m0 requests -> grant stays 10 until m1_cyc drops.
//  5 TIMEOUT_CYCLES=8, slave never acks -> m0_err_o=1 exactly at the 8th cycle of stb, s_stb_o=0 then.
//  6 wb_rst_i pulsed while G1 with stb pending -> next cycle s_cyc_o=0, grant_o=00, no ack/err out.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: two-master Wishbone B3 classic arbiter in front of one SDRAM port.
// Whole-cycle grants with round-robin or fixed priority, plus a per-transfer ack watchdog.
module wb_sdram_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter bit ROUND_ROBIN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      grant;
  logic            stb_raw, done, fire;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  // last_q=1 means m1 was served last, so m0 wins the next tie under round-robin
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE:
        if (m0_cyc_i && m1_cyc_i) state_d = (ROUND_ROBIN && last_q) ? G0 : G1;
        else if (m0_cyc_i) state_d = G0;
        else if (m1_cyc_i) state_d = G1;
      G0:
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      G1:
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  assign grant   = {state_q == G1, state_q == G0};
  assign grant_o = grant;
  assign s_adr_o = grant[1] ? m1_adr_i : grant[0] ? m0_adr_i : '0;
  assign s_dat_o = grant[1] ? m1_dat_i : grant[0] ? m0_dat_i : '0;
  assign s_sel_o = grant[1] ? m1_sel_i : grant[0] ? m0_sel_i : '0;
  assign s_we_o  = (grant[1] & m1_we_i) | (grant[0] & m0_we_i);
  assign s_cyc_o = (grant[1] & m1_cyc_i) | (grant[0] & m0_cyc_i);
  assign stb_raw = (grant[1] & m1_stb_i) | (grant[0] & m0_stb_i);
  assign done    = s_ack_i | s_err_i;
  // Fire on the last allowed wait cycle; the strobe is withdrawn so the slave drops the access
  assign fire    = (TIMEOUT_CYCLES != 0) && stb_raw && !done && (cnt_q == TO_LAST);
  assign s_stb_o = stb_raw & ~fire;
  assign cnt_d   = (!stb_raw || done || fire) ? '0 : cnt_q + 1'b1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = grant[0] & s_ack_i;
  assign m1_ack_o = grant[1] & s_ack_i;
  assign m0_err_o = grant[0] & (s_err_i | fire);
  assign m1_err_o = grant[1] & (s_err_i | fire);
endmodule
